// File: rtl/pixel_window_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a 3x3 shift window
// whose contents, with the centre coordinates, go straight to the sharpening stage.
module pixel_window_3x3 #(
   parameter  int PIX_W = 8,
   parameter  int IMG_W = 16,
   parameter  int IMG_H = 16,
   localparam int CW    = $clog2(IMG_W),
   localparam int RW    = $clog2(IMG_H)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pix_in_valid,
   input  logic [PIX_W-1:0]   pix_in,
   output logic               win_valid,
   output logic [9*PIX_W-1:0] win,
   output logic [RW-1:0]      win_row,
   output logic [CW-1:0]      win_col,
   output logic               frame_done
);

   // Handshake: pix_in_valid qualifies pix_in for one cycle; win_valid qualifies
   // win/win_row/win_col for one cycle. There is no ready: every valid is consumed.

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic             col_last;
   logic             row_last;
   logic [PIX_W-1:0] lb0 [IMG_W];
   logic [PIX_W-1:0] lb1 [IMG_W];
   logic [PIX_W-1:0] t0;
   logic [PIX_W-1:0] t1;

   assign col_last = (col == COL_LAST);
   assign row_last = (row == ROW_LAST);
   assign t0       = lb0[col];
   assign t1       = lb1[col];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col <= '0;
         row <= '0;
      end else if (pix_in_valid) begin
         if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // Line buffers are never cleared; output gating on row/col hides stale data.
   always_ff @(posedge clk) begin
      if (pix_in_valid) begin
         lb0[col] <= t1;
         lb1[col] <= pix_in;
      end
   end

   // The shift window is the output register itself: element k=3*r+c.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win        <= '0;
         win_row    <= '0;
         win_col    <= '0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         win_valid  <= pix_in_valid && (row >= RW'(2)) && (col >= CW'(2));
         frame_done <= pix_in_valid && row_last && col_last;
         if (pix_in_valid) begin
            for (int r = 0; r < 3; r++) begin
               win[(3*r)*PIX_W   +: PIX_W] <= win[(3*r+1)*PIX_W +: PIX_W];
               win[(3*r+1)*PIX_W +: PIX_W] <= win[(3*r+2)*PIX_W +: PIX_W];
            end
            win[2*PIX_W +: PIX_W] <= t0;
            win[5*PIX_W +: PIX_W] <= t1;
            win[8*PIX_W +: PIX_W] <= pix_in;
            win_row <= row - RW'(1);
            win_col <= col - CW'(1);
         end
      end
   end

endmodule
